// File: rtl/disp_mux_test_amisha_if.sv
// Board-side signal bundle for the four-digit display test block:
// switch/button inputs and the multiplexed anode/segment drive.
interface disp_mux_test_amisha_if;
   // No valid/ready handshake here: btn_amisha bits are level load strobes,
   // sampled on every rising edge, and an/sseg are continuously valid outputs.
   logic [3:0] btn_amisha;
   logic [7:0] sw_amisha;
   logic [3:0] an_amisha;
   logic [7:0] sseg_amisha;

   modport master (output btn_amisha, output sw_amisha,
                   input  an_amisha,  input  sseg_amisha);
   modport slave  (input  btn_amisha, input  sw_amisha,
                   output an_amisha,  output sseg_amisha);
endinterface

// File: rtl/disp_mux_test_amisha.sv
// Four-digit time-multiplexed seven-segment test block: buttons latch switches into
// per-digit registers. Optional macro DISP_MUX_TEST_BTN_SYNC_EN adds a 2-flop button synchronizer.
module disp_mux_test_amisha #(
   parameter int N = 18
) (
   input logic                     clk_amisha,
   input logic                     reset_amisha,
   disp_mux_test_amisha_if.slave   io
);

   logic [N-1:0] q;
   logic [1:0]   sel;
   logic [7:0]   digit [4];
   logic [3:0]   load;

`ifdef DISP_MUX_TEST_BTN_SYNC_EN
   logic [3:0] btn_meta;
   logic [3:0] btn_sync;

   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         btn_meta <= 4'b0000;
         btn_sync <= 4'b0000;
      end else begin
         btn_meta <= io.btn_amisha;
         btn_sync <= btn_meta;
      end
   end

   assign load = btn_sync;
`else
   assign load = io.btn_amisha;
`endif

   // Free-running refresh counter; the top two bits pick the active digit.
   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         q <= '0;
      end else begin
         q <= q + {{(N-1){1'b0}}, 1'b1};
      end
   end

   assign sel = q[N-1:N-2];

   // Level-sensitive loads: a held button reloads every cycle, no priority.
   always_ff @(posedge clk_amisha or posedge reset_amisha) begin
      if (reset_amisha) begin
         for (int k = 0; k < 4; k++) begin
            digit[k] <= 8'hFF;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (load[k]) begin
               digit[k] <= io.sw_amisha;
            end
         end
      end
   end

   always_comb begin
      io.an_amisha   = 4'b1110;
      io.sseg_amisha = digit[0];
      case (sel)
         2'b00: begin io.an_amisha = 4'b1110; io.sseg_amisha = digit[0]; end
         2'b01: begin io.an_amisha = 4'b1101; io.sseg_amisha = digit[1]; end
         2'b10: begin io.an_amisha = 4'b1011; io.sseg_amisha = digit[2]; end
         2'b11: begin io.an_amisha = 4'b0111; io.sseg_amisha = digit[3]; end
         default: begin io.an_amisha = 4'b1110; io.sseg_amisha = digit[0]; end
      endcase
   end

endmodule

// File: tb/tb_disp_mux_test_amisha.sv
// Self-checking bench for disp_mux_test_amisha (N=4): a cycle model pushes the
// expected {an,sseg} per clock into a queue that is popped against the DUT.
module tb_disp_mux_test_amisha;

   localparam int N = 4;

   logic clk;
   logic rst;

   disp_mux_test_amisha_if bus ();

   disp_mux_test_amisha #(.N(N)) dut (
      .clk_amisha   (clk),
      .reset_amisha (rst),
      .io           (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [11:0] exp_q[$];
   int          n_vec;
   int          n_err;

   logic [N-1:0] m_q;
   logic [7:0]   m_d [4];
   logic [3:0]   m_s1;
   logic [3:0]   m_s2;

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got an=%b sseg=%h, expected an=%b sseg=%h",
                  tag, got[11:8], got[7:0], exp[11:8], exp[7:0]);
      end
   endtask

   function automatic logic [11:0] model_out();
      logic [1:0] s;
      logic [3:0] an;
      s  = m_q[N-1:N-2];
      an = 4'b1111;
      an[s] = 1'b0;
      return {an, m_d[s]};
   endfunction

   task automatic model_reset();
      m_q  = '0;
      m_s1 = 4'b0000;
      m_s2 = 4'b0000;
      for (int k = 0; k < 4; k++) m_d[k] = 8'hFF;
   endtask

   // ---------------- driver ----------------
   // Drive inputs for one clock, advance the model through that edge, then
   // compare on the following falling edge.
   task automatic cycle(input string tag, input logic [3:0] b, input logic [7:0] s);
      logic [3:0]  ld;
      logic [11:0] exp;
      bus.btn_amisha = b;
      bus.sw_amisha  = s;
`ifdef DISP_MUX_TEST_BTN_SYNC_EN
      ld   = m_s2;
      m_s2 = m_s1;
      m_s1 = b;
`else
      ld = b;
`endif
      for (int k = 0; k < 4; k++) if (ld[k]) m_d[k] = s;
      m_q = m_q + 1'b1;
      exp_q.push_back(model_out());
      @(posedge clk);
      @(negedge clk);
      exp = exp_q.pop_front();
      check(tag, {bus.an_amisha, bus.sseg_amisha}, exp);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 4'b0000, 8'($urandom_range(0, 255)));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      bus.btn_amisha = 4'b0000;
      bus.sw_amisha  = 8'h00;
      rst = 1'b1;
      model_reset();
      #1;
      check("reset_out", {bus.an_amisha, bus.sseg_amisha}, {4'b1110, 8'hFF});

      // Buttons asserted while reset is held must not load anything.
      bus.btn_amisha = 4'b1111;
      bus.sw_amisha  = 8'h55;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_prio", {bus.an_amisha, bus.sseg_amisha}, {4'b1110, 8'hFF});
      bus.btn_amisha = 4'b0000;
      rst = 1'b0;

      idle("blank_scan", 17);

      cycle("load_1010", 4'b1010, 8'h19);
      idle("scan_1010", 16);

      cycle("load_d1", 4'b0010, 8'h3F);
      cycle("load_d3", 4'b1000, 8'h02);
      idle("scan_d1d3", 16);

      cycle("load_all", 4'b1111, 8'h7F);
      idle("scan_all", 16);

      cycle("hold_d0", 4'b0001, 8'h19);
      cycle("hold_d0", 4'b0001, 8'h3F);
      cycle("hold_d0", 4'b0001, 8'h02);
      idle("freeze_d0", 16);

      for (int i = 0; i < 40; i++) begin
         cycle("random", (i % 3 == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
               8'($urandom_range(0, 255)));
      end

      // Walk to a cycle where digit 2 is being shown, then hit reset asynchronously.
      begin
         int guard;
         guard = 0;
         while (m_q[N-1:N-2] != 2'b10 && guard < 16) begin
            cycle("align", 4'b0000, 8'h00);
            guard++;
         end
         check("align_sel", {bus.an_amisha, 8'h00}, {4'b1011, 8'h00});
      end
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check("async_reset", {bus.an_amisha, bus.sseg_amisha}, {4'b1110, 8'hFF});
      @(negedge clk);
      check("reset_hold", {bus.an_amisha, bus.sseg_amisha}, {4'b1110, 8'hFF});
      rst = 1'b0;
      idle("post_reset", 17);

      cycle("reload", 4'b0100, 8'hA5);
      idle("reload_scan", 16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past limit, got no finish, expected finish");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/disp_mux_test_amisha.md
Name: disp_mux_test_amisha

Overview:
- Four-digit, time-multiplexed seven-segment display test block.
- Each of four pushbuttons latches the 8-bit switch value into its own digit register.
- An internal refresh counter cycles through the four digits, driving one active-low anode at a time along with that digit's raw 8-bit segment pattern.
- Sits between the board I/O (switches, buttons) and the four-digit LED display.

Parameters:
- N, 18, refresh counter width; each digit is shown for 2^(N-2) clock cycles. Minimum 2; benches use N=4.

Ports:
- clk_amisha  input  1  system clock; all state updates on the rising edge.
- reset_amisha  input  1  asynchronous, active-high reset.
- btn_amisha  input  4  load strobes, active-high; bit k loads digit k.
- sw_amisha  input  8  segment pattern to load, active-low, bit order {dp,g,f,e,d,c,b,a}.
- an_amisha  output  4  digit anodes, active-low, exactly one low at any time.
- sseg_amisha  output  8  segment drive, active-low, same bit order as sw_amisha.

Behaviour:
- Interface: one clock (clk_amisha); reset (reset_amisha) is asynchronous and active-high.
- Digit registers d0..d3, each 8 bits:
  - On a rising edge with btn_amisha[k]=1, dk <= sw_amisha.
  - Otherwise dk holds its value.
- Buttons are level-sensitive, not edge-detected. Holding a button reloads every cycle, so dk tracks sw_amisha while the button is held.
- Simultaneous buttons: every asserted bit loads the same sw_amisha value in the same cycle. No priority between buttons.
- Load latency (macro off): the new pattern is visible on sseg_amisha one cycle after the loading edge, whenever that digit is selected.
- Refresh counter q, N bits:
  - Increments by 1 every clock.
  - Wraps from 2^N-1 to 0 with no gap.
  - sel = q[N-1:N-2].
- Output mapping, purely combinational from sel and the digit registers, glitch-free per clock:
  - sel=00: an_amisha=1110, sseg_amisha=d0.
  - sel=01: an_amisha=1101, sseg_amisha=d1.
  - sel=10: an_amisha=1011, sseg_amisha=d2.
  - sel=11: an_amisha=0111, sseg_amisha=d3.
- Reset (asynchronous, takes effect immediately):
  - q=0 and d0..d3=8'hFF (blank).
  - Outputs during and right after reset: an_amisha=1110, sseg_amisha=8'hFF.
  - Reset asserted mid-scan restarts the scan at digit 0 and discards all loaded patterns.
  - Reset has priority over button loads in the same cycle.
- No X on any output after reset.

Optional Feature:
- Macro: DISP_MUX_TEST_BTN_SYNC_EN.
- Defined:
  - btn_amisha passes through a two-flop synchronizer, reset to 0, before use as load strobes.
  - Load latency becomes 3 cycles: the register updates on the third rising edge after the button is sampled high.
  - A 1-cycle button pulse still produces exactly one load, of the sw_amisha value present at that third edge.
- Undefined: btn_amisha is used directly, with the 1-cycle latency above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset with N=4, btn=0 -> an_amisha=1110, sseg_amisha=FF. Release reset and run 16 cycles -> an_amisha steps 1110, 1101, 1011, 0111, holding 4 cycles each, sseg_amisha=FF throughout, then wraps to 1110.
- btn=4'b1010, sw=25 for one cycle, then btn=0 -> d1=d3=8'h19 and d0=d2=FF. sseg_amisha shows 19 while an_amisha=1101 or 0111, and FF otherwise.
- btn=4'b0010, sw=63, then btn=4'b1000, sw=2 -> d1=8'h3F, d3=8'h02; d0 and d2 unchanged.
- btn=4'b1111, sw=127 -> all digits read 8'h7F over a full scan.
- btn held on bit 0 while sw changes 25 -> 63 -> 2 -> d0 follows sw each cycle. Release -> d0 freezes at the last value.
- Assert reset mid-scan (sel=10) with digits loaded -> immediately an_amisha=1110, sseg_amisha=FF, all digits blank. With DISP_MUX_TEST_BTN_SYNC_EN defined, repeat the load test and check 3-cycle latency.
